// File: rtl/alu_rs_pkg.sv
// Shared ALU definitions: opcode constants, data widths and reservation-station defaults.
// The reservation station passes opcodes through untouched; the constants serve the ALU and benches.
package alu_rs_pkg;

  localparam int RS_SIZE_DEF = 8;
  localparam int ROB_W_DEF   = 4;
  localparam int DATA_W      = 32;
  localparam int OP_W        = 6;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP  = 6'd0;
  localparam op_t OP_ADD  = 6'd1;
  localparam op_t OP_SUB  = 6'd2;
  localparam op_t OP_AND  = 6'd3;
  localparam op_t OP_OR   = 6'd4;
  localparam op_t OP_XOR  = 6'd5;
  localparam op_t OP_SLL  = 6'd6;
  localparam op_t OP_SRL  = 6'd7;
  localparam op_t OP_SRA  = 6'd8;
  localparam op_t OP_SLT  = 6'd9;
  localparam op_t OP_SLTU = 6'd10;
  localparam op_t OP_LUI  = 6'd11;
  localparam op_t OP_AUIPC = 6'd12;
  localparam op_t OP_JAL  = 6'd13;
  localparam op_t OP_JALR = 6'd14;
  localparam op_t OP_BEQ  = 6'd15;
  localparam op_t OP_BNE  = 6'd16;
  localparam op_t OP_BLT  = 6'd17;
  localparam op_t OP_BGE  = 6'd18;
  localparam op_t OP_BLTU = 6'd19;
  localparam op_t OP_BGEU = 6'd20;

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit encoder: valid when any request is set, idx of the lowest one.
module rs_prio_enc #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ops until both operands are ready,
// snoops ALU/LSB result broadcasts, and issues the lowest ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int ROB_W   = ROB_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              roll,

  input  logic              dsp_flag,
  input  logic [OP_W-1:0]   dsp_op,
  input  logic [DATA_W-1:0] dsp_imm,
  input  logic [DATA_W-1:0] dsp_PC,
  input  logic [DATA_W-1:0] dsp_Vj,
  input  logic [DATA_W-1:0] dsp_Vk,
  input  logic              dsp_j_rdy,
  input  logic              dsp_k_rdy,
  input  logic [ROB_W-1:0]  dsp_Qj,
  input  logic [ROB_W-1:0]  dsp_Qk,
  input  logic [ROB_W-1:0]  dsp_idx,
  output logic              RS_full,

  input  logic              ALU_flag,
  input  logic [ROB_W-1:0]  ALU_ROB_idx,
  input  logic [DATA_W-1:0] ALU_val,
  input  logic              LSB_flag,
  input  logic [ROB_W-1:0]  LSB_ROB_idx,
  input  logic [DATA_W-1:0] LSB_val,

  output logic              RS_flag,
  output logic [OP_W-1:0]   RS_op,
  output logic [DATA_W-1:0] RS_Vj,
  output logic [DATA_W-1:0] RS_Vk,
  output logic [ROB_W-1:0]  RS_idx,
  output logic [DATA_W-1:0] RS_imm,
  output logic [DATA_W-1:0] RS_PC
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] j_rdy;
  logic [RS_SIZE-1:0] k_rdy;
  logic [OP_W-1:0]    op_q   [RS_SIZE];
  logic [DATA_W-1:0]  vj_q   [RS_SIZE];
  logic [DATA_W-1:0]  vk_q   [RS_SIZE];
  logic [ROB_W-1:0]   qj_q   [RS_SIZE];
  logic [ROB_W-1:0]   qk_q   [RS_SIZE];
  logic [ROB_W-1:0]   dest_q [RS_SIZE];
  logic [DATA_W-1:0]  imm_q  [RS_SIZE];
  logic [DATA_W-1:0]  pc_q   [RS_SIZE];

  logic [RS_SIZE-1:0] free_req;
  logic [RS_SIZE-1:0] iss_req;
  logic               free_vld;
  logic               iss_vld;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   iss_idx;

  logic               dsp_acc;
  logic               dj_rdy;
  logic               dk_rdy;
  logic [DATA_W-1:0]  dvj;
  logic [DATA_W-1:0]  dvk;

  assign free_req = ~busy;
  assign iss_req  = busy & j_rdy & k_rdy;
  assign RS_full  = &busy;
  assign dsp_acc  = dsp_flag && free_vld && !RS_full;

  rs_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (
    .req   (free_req),
    .valid (free_vld),
    .idx   (free_idx)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(IDX_W)) u_issue_sel (
    .req   (iss_req),
    .valid (iss_vld),
    .idx   (iss_idx)
  );

  // Dispatch bypass: a result broadcast this same cycle is folded into the new entry.
  always_comb begin
    dj_rdy = dsp_j_rdy;
    dvj    = dsp_Vj;
    if (!dsp_j_rdy) begin
      if (ALU_flag && (ALU_ROB_idx == dsp_Qj)) begin
        dj_rdy = 1'b1;
        dvj    = ALU_val;
      end else if (LSB_flag && (LSB_ROB_idx == dsp_Qj)) begin
        dj_rdy = 1'b1;
        dvj    = LSB_val;
      end
    end
  end

  always_comb begin
    dk_rdy = dsp_k_rdy;
    dvk    = dsp_Vk;
    if (!dsp_k_rdy) begin
      if (ALU_flag && (ALU_ROB_idx == dsp_Qk)) begin
        dk_rdy = 1'b1;
        dvk    = ALU_val;
      end else if (LSB_flag && (LSB_ROB_idx == dsp_Qk)) begin
        dk_rdy = 1'b1;
        dvk    = LSB_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      j_rdy   <= '0;
      k_rdy   <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
      end
      RS_flag <= 1'b0;
      RS_op   <= '0;
      RS_Vj   <= '0;
      RS_Vk   <= '0;
      RS_idx  <= '0;
      RS_imm  <= '0;
      RS_PC   <= '0;
    end else if (rdy) begin
      if (roll) begin
        busy    <= '0;
        RS_flag <= 1'b0;
      end else begin
        // ALU takes precedence over LSB when both carry the same tag.
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && !j_rdy[i]) begin
            if (ALU_flag && (ALU_ROB_idx == qj_q[i])) begin
              vj_q[i]  <= ALU_val;
              j_rdy[i] <= 1'b1;
            end else if (LSB_flag && (LSB_ROB_idx == qj_q[i])) begin
              vj_q[i]  <= LSB_val;
              j_rdy[i] <= 1'b1;
            end
          end
          if (busy[i] && !k_rdy[i]) begin
            if (ALU_flag && (ALU_ROB_idx == qk_q[i])) begin
              vk_q[i]  <= ALU_val;
              k_rdy[i] <= 1'b1;
            end else if (LSB_flag && (LSB_ROB_idx == qk_q[i])) begin
              vk_q[i]  <= LSB_val;
              k_rdy[i] <= 1'b1;
            end
          end
        end

        if (iss_vld) begin
          RS_flag       <= 1'b1;
          RS_op         <= op_q[iss_idx];
          RS_Vj         <= vj_q[iss_idx];
          RS_Vk         <= vk_q[iss_idx];
          RS_idx        <= dest_q[iss_idx];
          RS_imm        <= imm_q[iss_idx];
          RS_PC         <= pc_q[iss_idx];
          busy[iss_idx] <= 1'b0;
        end else begin
          RS_flag <= 1'b0;
        end

        // The free slot is never the issuing slot: free means not busy at cycle start.
        if (dsp_acc) begin
          busy[free_idx]   <= 1'b1;
          op_q[free_idx]   <= dsp_op;
          vj_q[free_idx]   <= dvj;
          vk_q[free_idx]   <= dvk;
          j_rdy[free_idx]  <= dj_rdy;
          k_rdy[free_idx]  <= dk_rdy;
          qj_q[free_idx]   <= dsp_Qj;
          qk_q[free_idx]   <= dsp_Qk;
          dest_q[free_idx] <= dsp_idx;
          imm_q[free_idx]  <= dsp_imm;
          pc_q[free_idx]   <= dsp_PC;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: a slot-level model checked every cycle, plus literal spot checks.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N  = 8;
  localparam int RW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy = 1'b1;
  logic        roll = 1'b0;
  logic        dsp_flag = 1'b0;
  logic [5:0]  dsp_op = '0;
  logic [31:0] dsp_imm = '0, dsp_PC = '0, dsp_Vj = '0, dsp_Vk = '0;
  logic        dsp_j_rdy = 1'b0, dsp_k_rdy = 1'b0;
  logic [RW-1:0] dsp_Qj = '0, dsp_Qk = '0, dsp_idx = '0;
  logic        ALU_flag = 1'b0, LSB_flag = 1'b0;
  logic [RW-1:0] ALU_ROB_idx = '0, LSB_ROB_idx = '0;
  logic [31:0] ALU_val = '0, LSB_val = '0;

  logic        RS_full, RS_flag;
  logic [5:0]  RS_op;
  logic [31:0] RS_Vj, RS_Vk, RS_imm, RS_PC;
  logic [RW-1:0] RS_idx;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_rs #(.RS_SIZE(N), .ROB_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .roll(roll),
    .dsp_flag(dsp_flag), .dsp_op(dsp_op), .dsp_imm(dsp_imm), .dsp_PC(dsp_PC),
    .dsp_Vj(dsp_Vj), .dsp_Vk(dsp_Vk), .dsp_j_rdy(dsp_j_rdy), .dsp_k_rdy(dsp_k_rdy),
    .dsp_Qj(dsp_Qj), .dsp_Qk(dsp_Qk), .dsp_idx(dsp_idx), .RS_full(RS_full),
    .ALU_flag(ALU_flag), .ALU_ROB_idx(ALU_ROB_idx), .ALU_val(ALU_val),
    .LSB_flag(LSB_flag), .LSB_ROB_idx(LSB_ROB_idx), .LSB_val(LSB_val),
    .RS_flag(RS_flag), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_idx(RS_idx), .RS_imm(RS_imm), .RS_PC(RS_PC)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          busy;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    bit          jr, kr;
    logic [RW-1:0] qj, qk, dest;
  } ent_t;

  ent_t m [N];
  bit          m_flag;
  logic [5:0]  m_op;
  logic [31:0] m_vj, m_vk, m_imm, m_pc;
  logic [RW-1:0] m_idx;

  // Resolve a waiting operand against this cycle's broadcasts (ALU first).
  task automatic snoop(input logic [RW-1:0] tag, inout bit r, inout logic [31:0] v);
    if (!r) begin
      if (ALU_flag && ALU_ROB_idx == tag) begin r = 1'b1; v = ALU_val; end
      else if (LSB_flag && LSB_ROB_idx == tag) begin r = 1'b1; v = LSB_val; end
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    ent_t snap [N];
    int iss, slot;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m[i].busy = 1'b0;
      m_flag = 1'b0; m_op = '0; m_vj = '0; m_vk = '0; m_imm = '0; m_pc = '0; m_idx = '0;
    end else if (rdy) begin
      if (roll) begin
        for (int i = 0; i < N; i++) m[i].busy = 1'b0;
        m_flag = 1'b0;
      end else begin
        snap = m;
        iss = -1;
        slot = -1;
        for (int i = N - 1; i >= 0; i--) begin
          if (snap[i].busy && snap[i].jr && snap[i].kr) iss = i;
          if (!snap[i].busy) slot = i;
        end
        for (int i = 0; i < N; i++) begin
          if (m[i].busy) begin
            snoop(m[i].qj, m[i].jr, m[i].vj);
            snoop(m[i].qk, m[i].kr, m[i].vk);
          end
        end
        m_flag = (iss >= 0);
        if (iss >= 0) begin
          m_op = snap[iss].op; m_vj = snap[iss].vj; m_vk = snap[iss].vk;
          m_idx = snap[iss].dest; m_imm = snap[iss].imm; m_pc = snap[iss].pc;
          m[iss].busy = 1'b0;
        end
        if (dsp_flag && slot >= 0) begin
          m[slot].busy = 1'b1; m[slot].op = dsp_op;
          m[slot].jr = dsp_j_rdy; m[slot].vj = dsp_Vj; m[slot].qj = dsp_Qj;
          m[slot].kr = dsp_k_rdy; m[slot].vk = dsp_Vk; m[slot].qk = dsp_Qk;
          m[slot].dest = dsp_idx; m[slot].imm = dsp_imm; m[slot].pc = dsp_PC;
          snoop(dsp_Qj, m[slot].jr, m[slot].vj);
          snoop(dsp_Qk, m[slot].kr, m[slot].vk);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("full", RS_full, m_full());
      check("flag", RS_flag, m_flag);
      check("op", RS_op, m_op);
      check("vj", RS_Vj, m_vj);
      check("vk", RS_Vk, m_vk);
      check("idx", RS_idx, m_idx);
      check("imm", RS_imm, m_imm);
      check("pc", RS_PC, m_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    dsp_flag = 1'b0; ALU_flag = 1'b0; LSB_flag = 1'b0; roll = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vj, input bit jr, input logic [RW-1:0] qj,
                      input logic [31:0] vk, input bit kr, input logic [RW-1:0] qk, input logic [RW-1:0] idx);
    dsp_flag = 1'b1; dsp_op = op;
    dsp_Vj = vj; dsp_j_rdy = jr; dsp_Qj = qj;
    dsp_Vk = vk; dsp_k_rdy = kr; dsp_Qk = qk;
    dsp_idx = idx; dsp_imm = 32'h100 + 32'(idx); dsp_PC = 32'h4000 + 32'(idx) * 4;
  endtask

  task automatic alu_b(input logic [RW-1:0] tag, input logic [31:0] v);
    ALU_flag = 1'b1; ALU_ROB_idx = tag; ALU_val = v;
  endtask

  task automatic lsb_b(input logic [RW-1:0] tag, input logic [31:0] v);
    LSB_flag = 1'b1; LSB_ROB_idx = tag; LSB_val = v;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_flag", RS_flag, 0);
    check("rst_full", RS_full, 0);
    check("rst_op", RS_op, 0);
    check("rst_vj", RS_Vj, 0);
    check("rst_idx", RS_idx, 0);
    check("rst_pc", RS_PC, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // basic issue latency
    disp(OP_ADD, 5, 1, 0, 7, 1, 0, 3); tick();
    check("add_early", RS_flag, 0);
    tick();
    check("add_flag", RS_flag, 1);
    check("add_op", RS_op, OP_ADD);
    check("add_vj", RS_Vj, 5);
    check("add_vk", RS_Vk, 7);
    check("add_idx", RS_idx, 3);
    check("add_imm", RS_imm, 32'h103);
    tick();
    check("add_after", RS_flag, 0);

    // wakeup from ALU broadcast
    disp(OP_SUB, 0, 0, 2, 3, 1, 0, 4); tick(); tick();
    alu_b(2, 32'h10); tick();
    check("wake_early", RS_flag, 0);
    tick();
    check("wake_flag", RS_flag, 1);
    check("wake_vj", RS_Vj, 32'h10);
    check("wake_idx", RS_idx, 4);

    // dispatch bypass from LSB broadcast
    disp(OP_XOR, 9, 1, 0, 0, 0, 6, 5); lsb_b(6, 32'hABCD); tick(); tick();
    check("byp_flag", RS_flag, 1);
    check("byp_vk", RS_Vk, 32'hABCD);
    check("byp_vj", RS_Vj, 9);

    // ALU wins over LSB on tag collision: bypass then wakeup
    disp(OP_OR, 0, 0, 7, 1, 1, 0, 6); alu_b(7, 32'h111); lsb_b(7, 32'h222); tick(); tick();
    check("col_byp_vj", RS_Vj, 32'h111);
    disp(OP_AND, 0, 0, 1, 2, 1, 0, 7); tick();
    alu_b(1, 32'h333); lsb_b(1, 32'h444); tick(); tick();
    check("col_wake_vj", RS_Vj, 32'h333);
    check("col_wake_idx", RS_idx, 7);
    tick();

    // fill the station with entry i waiting on tag 8+i
    for (int i = 0; i < N; i++) begin
      disp(OP_ADD, 0, 0, RW'(8 + i), 32'(i), 1, 0, RW'(i)); tick();
    end
    check("fill_full", RS_full, 1);
    disp(OP_ADD, 1, 1, 0, 1, 1, 0, 15); tick();
    check("ninth_full", RS_full, 1);
    check("ninth_flag", RS_flag, 0);
    alu_b(13, 32'h55); tick();
    check("e5_woken_full", RS_full, 1);
    disp(OP_ADD, 1, 1, 0, 1, 1, 0, 14); tick();
    check("e5_flag", RS_flag, 1);
    check("e5_idx", RS_idx, 5);
    check("e5_vj", RS_Vj, 32'h55);
    check("e5_full", RS_full, 0);
    tick();
    check("freed_not_reused", RS_flag, 0);

    // two ready at once: lower index first
    alu_b(9, 32'hA1); lsb_b(12, 32'hA4); tick(); tick();
    check("prio_first", RS_idx, 1);
    check("prio_first_vj", RS_Vj, 32'hA1);
    tick();
    check("prio_second", RS_idx, 4);
    check("prio_second_vj", RS_Vj, 32'hA4);

    // leave four busy entries (2,3,6,7) with entry 2 ready, then roll
    alu_b(8, 32'hB0); tick();
    alu_b(10, 32'hC2); tick();
    check("pre_roll_idx", RS_idx, 0);
    roll = 1'b1; disp(OP_ADD, 1, 1, 0, 1, 1, 0, 14); tick();
    check("roll_flag", RS_flag, 0);
    check("roll_full", RS_full, 0);
    alu_b(11, 32'hD3); lsb_b(14, 32'hD6); tick();
    alu_b(15, 32'hD7); tick(); tick();
    check("roll_no_issue", RS_flag, 0);

    // rdy low for three cycles mid-stream
    disp(OP_ADD, 32'h21, 1, 0, 32'h31, 1, 0, 1); tick();
    disp(OP_ADD, 32'h22, 1, 0, 32'h32, 1, 0, 2); tick();
    check("frz_first", RS_idx, 1);
    rdy = 1'b0;
    disp(OP_ADD, 32'h99, 1, 0, 32'h99, 1, 0, 9); alu_b(3, 32'hEE);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("frz_flag", RS_flag, 1);
      check("frz_idx", RS_idx, 1);
      check("frz_vj", RS_Vj, 32'h21);
    end
    rdy = 1'b1;
    disp(OP_SUB, 32'h23, 1, 0, 32'h33, 1, 0, 3); tick();
    check("res_second", RS_idx, 2);
    check("res_second_vk", RS_Vk, 32'h32);
    tick();
    check("res_third", RS_idx, 3);
    check("res_third_op", RS_op, OP_SUB);
    tick();
    check("res_idle", RS_flag, 0);

    // asynchronous reset in the middle of operation
    disp(OP_ADD, 4, 1, 0, 4, 1, 0, 9); tick();
    disp(OP_ADD, 0, 0, 12, 4, 1, 0, 10); tick();
    check("pre_rst_idx", RS_idx, 9);
    #2 rst_n = 1'b0;
    #1;
    check("arst_flag", RS_flag, 0);
    check("arst_idx", RS_idx, 0);
    check("arst_vj", RS_Vj, 0);
    check("arst_full", RS_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    alu_b(12, 32'h77); tick(); tick();
    check("arst_no_partial", RS_flag, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
